// File: rtl/id_operand_stage.sv
// Decode-stage front end: ID pipeline register, inst SRAM hold buffer,
// priority operand forwarding and load-use stall detection.
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  id_stall,
    input  logic                                  id_flush,
    input  logic                                  if_valid,
    input  logic [DATA_W-1:0]                     if_pc,
    input  logic [31:0]                           inst_rdata,
    input  logic                                  use_rs,
    input  logic                                  use_rt,
    input  logic [NUM_FWD*(2+REG_AW+DATA_W)-1:0]  fwd_bus,
    input  logic                                  wb_we,
    input  logic [REG_AW-1:0]                     wb_waddr,
    input  logic [DATA_W-1:0]                     wb_wdata,
    input  logic [DATA_W-1:0]                     rf_rdata1,
    input  logic [DATA_W-1:0]                     rf_rdata2,
    output logic [REG_AW-1:0]                     rf_raddr1,
    output logic [REG_AW-1:0]                     rf_raddr2,
    output logic                                  id_valid,
    output logic [DATA_W-1:0]                     id_pc,
    output logic [31:0]                           id_inst,
    output logic [DATA_W-1:0]                     rs_val,
    output logic [DATA_W-1:0]                     rt_val,
    output logic                                  stallreq,
    output logic [CNT_W-1:0]                      stall_cnt
);

    localparam int SW = 2 + REG_AW + DATA_W;

    typedef struct packed {
        logic              hit;
        logic              is_load;
        logic [DATA_W-1:0] data;
    } fwd_res_t;

    // Scan oldest to youngest so the lowest-index (youngest) match overwrites.
    function automatic fwd_res_t fwd_lookup(input logic [REG_AW-1:0] a,
                                            input logic [NUM_FWD*SW-1:0] bus);
        fwd_res_t       r;
        logic [SW-1:0]  src;
        r = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            src = bus[i*SW +: SW];
            if (src[SW-1] && (src[DATA_W +: REG_AW] == a)) begin
                r.hit     = 1'b1;
                r.is_load = src[SW-2];
                r.data    = src[DATA_W-1:0];
            end
        end
        return r;
    endfunction

    logic              id_valid_q,   id_valid_d;
    logic [DATA_W-1:0] id_pc_q,      id_pc_d;
    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       inst_hold_q,  inst_hold_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    fwd_res_t          rs_res, rt_res;
    logic [REG_AW-1:0] rs_addr, rt_addr;
    logic              rs_hazard, rt_hazard;

    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        hold_valid_d = hold_valid_q;
        inst_hold_d  = inst_hold_q;
        if (id_flush) begin
            id_valid_d   = 1'b0;
            id_pc_d      = '0;
            hold_valid_d = 1'b0;
        end else if (id_stall) begin
            // The SRAM word is only valid one cycle after load; latch it on the first stall edge.
            if (!hold_valid_q && id_valid_q) begin
                inst_hold_d  = inst_rdata;
                hold_valid_d = 1'b1;
            end
        end else begin
            id_valid_d   = if_valid;
            id_pc_d      = if_pc;
            hold_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallreq && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            hold_valid_q <= 1'b0;
            inst_hold_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            hold_valid_q <= hold_valid_d;
            inst_hold_q  <= inst_hold_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign stall_cnt = stall_cnt_q;
    assign id_inst   = !id_valid_q ? 32'd0 : (hold_valid_q ? inst_hold_q : inst_rdata);

    assign rs_addr   = id_inst[25:21];
    assign rt_addr   = id_inst[20:16];
    assign rf_raddr1 = rs_addr;
    assign rf_raddr2 = rt_addr;

    always_comb begin
        rs_res = fwd_lookup(rs_addr, fwd_bus);
        rt_res = fwd_lookup(rt_addr, fwd_bus);

        if (rs_addr == '0)                      rs_val = '0;
        else if (rs_res.hit)                    rs_val = rs_res.data;
        else if (wb_we && (wb_waddr == rs_addr)) rs_val = wb_wdata;
        else                                    rs_val = rf_rdata1;

        if (rt_addr == '0)                      rt_val = '0;
        else if (rt_res.hit)                    rt_val = rt_res.data;
        else if (wb_we && (wb_waddr == rt_addr)) rt_val = wb_wdata;
        else                                    rt_val = rf_rdata2;

        rs_hazard = use_rs && id_valid_q && (rs_addr != '0) && rs_res.hit && rs_res.is_load;
        rt_hazard = use_rt && id_valid_q && (rt_addr != '0) && rt_res.hit && rt_res.is_load;
        stallreq  = rs_hazard || rt_hazard;
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: ID register, hold buffer, forwarding,
// load-use stall and saturating stall counter (CNT_W=2).
`timescale 1ns/1ps
module tb_id_operand_stage;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 2;
  localparam int SW      = 2 + REG_AW + DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    id_stall, id_flush, if_valid;
  logic [DATA_W-1:0]       if_pc;
  logic [31:0]             inst_rdata;
  logic                    use_rs, use_rt;
  logic [NUM_FWD*SW-1:0]   fwd_bus;
  logic                    wb_we;
  logic [REG_AW-1:0]       wb_waddr;
  logic [DATA_W-1:0]       wb_wdata, rf_rdata1, rf_rdata2;
  logic [REG_AW-1:0]       rf_raddr1, rf_raddr2;
  logic                    id_valid;
  logic [DATA_W-1:0]       id_pc;
  logic [31:0]             id_inst;
  logic [DATA_W-1:0]       rs_val, rt_val;
  logic                    stallreq;
  logic [CNT_W-1:0]        stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  id_operand_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .id_flush(id_flush),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
    .use_rs(use_rs), .use_rt(use_rt), .fwd_bus(fwd_bus),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rs_val(rs_val), .rt_val(rt_val), .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time limit (got running, need finished)");
    $fatal(1, "timeout");
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [SW-1:0] fwd_src(input logic we, input logic ld,
                                            input logic [4:0] a, input logic [31:0] d);
    return {we, ld, a, d};
  endfunction

  function automatic logic [31:0] make_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'h0020};
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; id_stall = 1'b0; id_flush = 1'b0; if_valid = 1'b0; if_pc = '0;
    inst_rdata = '0; use_rs = 1'b0; use_rt = 1'b0; fwd_bus = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    rf_rdata1 = 32'h11111111; rf_rdata2 = 32'h22222222;
    tick(); tick();

    check("rst_id_valid",  32'(id_valid), 32'd0);
    check("rst_id_pc",     id_pc, 32'd0);
    check("rst_id_inst",   id_inst, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_stallreq",  32'(stallreq), 32'd0);

    // first fetch into ID
    rst = 1'b0; if_valid = 1'b1; if_pc = 32'hBFC00000;
    tick();
    inst_rdata = 32'h3C011234;
    settle();
    check("load_id_valid", 32'(id_valid), 32'd1);
    check("load_id_pc",    id_pc, 32'hBFC00000);
    check("load_id_inst",  id_inst, 32'h3C011234);
    check("load_raddr2",   32'(rf_raddr2), 32'd1);
    check("load_raddr1",   32'(rf_raddr1), 32'd0);

    // youngest forward wins
    inst_rdata = make_inst(5'd3, 5'd0); use_rs = 1'b1; use_rt = 1'b0;
    fwd_bus = {fwd_src(1'b1, 1'b0, 5'd3, 32'h00005555), fwd_src(1'b1, 1'b0, 5'd3, 32'hAAAA0000)};
    settle();
    check("fwd_raddr1",     32'(rf_raddr1), 32'd3);
    check("fwd_young_val",  rs_val, 32'hAAAA0000);
    check("fwd_young_stl",  32'(stallreq), 32'd0);
    fwd_bus = {fwd_src(1'b1, 1'b0, 5'd3, 32'h00005555), fwd_src(1'b0, 1'b0, 5'd3, 32'hAAAA0000)};
    settle();
    check("fwd_mem_val",    rs_val, 32'h00005555);
    fwd_bus = {fwd_src(1'b1, 1'b1, 5'd3, 32'h00005555), fwd_src(1'b1, 1'b0, 5'd3, 32'hAAAA0000)};
    settle();
    check("old_load_nostl", 32'(stallreq), 32'd0);
    check("old_load_val",   rs_val, 32'hAAAA0000);
    fwd_bus = {fwd_src(1'b1, 1'b0, 5'd3, 32'h00005555), fwd_src(1'b1, 1'b1, 5'd3, 32'hAAAA0000)};
    settle();
    check("young_load_stl", 32'(stallreq), 32'd1);
    fwd_bus = '0;

    // load-use on rt with one stall cycle
    inst_rdata = make_inst(5'd0, 5'd4); use_rs = 1'b0; use_rt = 1'b1;
    fwd_bus = {fwd_src(1'b0, 1'b0, 5'd0, 32'd0), fwd_src(1'b1, 1'b1, 5'd4, 32'd0)};
    settle();
    check("lu_stallreq", 32'(stallreq), 32'd1);
    id_stall = 1'b1;
    tick();
    inst_rdata = 32'hDEADBEEF;
    settle();
    check("hold_inst",      id_inst, make_inst(5'd0, 5'd4));
    check("hold_stall_cnt", 32'(stall_cnt), 32'd1);
    check("hold_id_pc",     id_pc, 32'hBFC00000);
    fwd_bus = '0; id_stall = 1'b0; if_pc = 32'hBFC00004;
    tick();
    inst_rdata = 32'h00A51020;
    settle();
    check("rel_inst",      id_inst, 32'h00A51020);
    check("rel_id_pc",     id_pc, 32'hBFC00004);
    check("rel_stall_cnt", 32'(stall_cnt), 32'd1);

    // load match but operand unused, or register 0
    inst_rdata = make_inst(5'd0, 5'd4); use_rt = 1'b0;
    fwd_bus = {fwd_src(1'b0, 1'b0, 5'd0, 32'd0), fwd_src(1'b1, 1'b1, 5'd4, 32'd0)};
    settle();
    check("unused_nostl", 32'(stallreq), 32'd0);
    use_rt = 1'b1; inst_rdata = make_inst(5'd0, 5'd0);
    fwd_bus = {fwd_src(1'b0, 1'b0, 5'd0, 32'd0), fwd_src(1'b1, 1'b1, 5'd0, 32'h0000CAFE)};
    settle();
    check("r0_nostl", 32'(stallreq), 32'd0);
    check("r0_rt_val", rt_val, 32'd0);

    // WB bypass, regfile fallback, MEM forward on rt
    fwd_bus = '0; use_rs = 1'b1; use_rt = 1'b1;
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h12345678;
    inst_rdata = make_inst(5'd7, 5'd9);
    settle();
    check("wb_rs_val", rs_val, 32'h12345678);
    check("rf_rt_val", rt_val, 32'h22222222);
    wb_we = 1'b0;
    settle();
    check("rf_rs_val", rs_val, 32'h11111111);
    fwd_bus = {fwd_src(1'b1, 1'b0, 5'd9, 32'h00000099), fwd_src(1'b0, 1'b0, 5'd0, 32'd0)};
    settle();
    check("mem_rt_val", rt_val, 32'h00000099);

    // flush together with stall during a hazard
    inst_rdata = make_inst(5'd0, 5'd4); use_rs = 1'b0; use_rt = 1'b1;
    fwd_bus = {fwd_src(1'b0, 1'b0, 5'd0, 32'd0), fwd_src(1'b1, 1'b1, 5'd4, 32'd0)};
    settle();
    check("fl_pre_stl", 32'(stallreq), 32'd1);
    id_flush = 1'b1; id_stall = 1'b1;
    tick();
    check("fl_id_valid",  32'(id_valid), 32'd0);
    check("fl_id_pc",     id_pc, 32'd0);
    check("fl_id_inst",   id_inst, 32'd0);
    check("fl_stallreq",  32'(stallreq), 32'd0);
    check("fl_stall_cnt", 32'(stall_cnt), 32'd2);

    // counter saturation at 3
    id_flush = 1'b0; id_stall = 1'b0; if_pc = 32'hBFC00008;
    tick();
    check("sat_pre_stl", 32'(stallreq), 32'd1);
    check("sat_pre_pc",  id_pc, 32'hBFC00008);
    id_stall = 1'b1;
    tick();
    inst_rdata = 32'h12340000;
    settle();
    check("sat_hold_inst", id_inst, make_inst(5'd0, 5'd4));
    check("sat_cnt_3",     32'(stall_cnt), 32'd3);
    for (int i = 0; i < 4; i++) tick();
    check("sat_cnt_hold", 32'(stall_cnt), 32'd3);
    check("sat_id_pc",    id_pc, 32'hBFC00008);
    check("sat_inst_5",   id_inst, make_inst(5'd0, 5'd4));

    // reset in the middle of a stall discards the hold buffer
    rst = 1'b1;
    tick();
    rst = 1'b0; id_stall = 1'b0; fwd_bus = '0;
    settle();
    check("mrst_id_valid",  32'(id_valid), 32'd0);
    check("mrst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("mrst_id_inst",   id_inst, 32'd0);
    if_pc = 32'hBFC0000C;
    tick();
    check("mrst_new_inst", id_inst, 32'h12340000);
    check("mrst_new_pc",   id_pc, 32'hBFC0000C);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
